// File: rtl/alarm_pkg.sv
// Shared types and sizing helpers for the alarm ring sequencer.
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_e;

  // Second counter must hold the larger of the two limits.
  function automatic int sec_cnt_w(input int snooze_secs, input int timeout_secs);
    int m;
    m = (snooze_secs > timeout_secs) ? snooze_secs : timeout_secs;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

  localparam int SEC_CNT_W = sec_cnt_w(540, 60);

endpackage

// File: rtl/alarm_ring_sequencer_beep_gen.sv
// beep_gen: registered on/off speaker cadence, ON_CYCLES high then OFF_CYCLES low.
// Phase restarts (next output high) whenever enable is low; output is 0 then.
module beep_gen #(
  parameter int ON_CYCLES  = 4,
  parameter int OFF_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic speaker
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ON_LIM  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LIM = CW'(OFF_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          on_q, on_d;
  logic          spk_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    on_d  = on_q;
    if (!enable) begin
      cnt_d = '0;
      on_d  = 1'b1;
    end else if (cnt_q == (on_q ? ON_LIM : OFF_LIM)) begin
      cnt_d = '0;
      on_d  = ~on_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      on_q  <= 1'b1;
      spk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      on_q  <= on_d;
      spk_q <= enable & on_q;
    end
  end

  assign speaker = spk_q;

endmodule

// File: rtl/alarm_ring_sequencer.sv
// Alarm speaker sequencer: arm, ring on match rise, snooze/stop, auto-silence.
// ALARM_BEEP_PATTERN_EN selects beep cadence; otherwise speaker_out is a continuous tone.
module alarm_ring_sequencer
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SECS       = 540,
  parameter int RING_TIMEOUT_SECS = 60,
  parameter int MAX_SNOOZE        = 3,
  parameter int BEEP_ON_CYCLES    = 4,
  parameter int BEEP_OFF_CYCLES   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sec_tick,
  input  logic match,
  input  logic alarm_en,
  input  logic snooze,
  input  logic stop,
  output logic speaker_out,
  output logic ringing,
  output logic snoozing,
  output logic [((MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1)-1:0] snooze_cnt
);

  localparam int SNZ_W = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int SEC_W = sec_cnt_w(SNOOZE_SECS, RING_TIMEOUT_SECS);
  localparam logic [SEC_W-1:0] RING_LIM  = SEC_W'(RING_TIMEOUT_SECS);
  localparam logic [SEC_W-1:0] SNZ_LIM   = SEC_W'(SNOOZE_SECS);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  state_e           state_q, state_d;
  logic             match_q;
  logic [SEC_W-1:0] sec_q, sec_d, sec_inc;
  logic [SNZ_W-1:0] snz_q, snz_d;
  logic             rise;

  assign rise    = match & ~match_q;
  assign sec_inc = sec_q + SEC_W'(1);

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    snz_d   = snz_q;
    if (!alarm_en) begin
      state_d = DISARMED;
      sec_d   = '0;
      snz_d   = '0;
    end else begin
      case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (rise) begin
            state_d = RINGING;
            sec_d   = '0;
          end
        end
        RINGING: begin
          // Snooze outranks a timeout landing on the same tick.
          if (stop) begin
            state_d = ARMED;
            sec_d   = '0;
            snz_d   = '0;
          end else if (snooze && (snz_q < SNZ_MAX)) begin
            state_d = SNOOZE;
            sec_d   = '0;
            snz_d   = snz_q + SNZ_W'(1);
          end else if (sec_tick && (sec_inc == RING_LIM)) begin
            state_d = ARMED;
            sec_d   = '0;
            snz_d   = '0;
          end else if (sec_tick) begin
            sec_d = sec_inc;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = ARMED;
            sec_d   = '0;
            snz_d   = '0;
          end else if (sec_tick && (sec_inc == SNZ_LIM)) begin
            state_d = RINGING;
            sec_d   = '0;
          end else if (sec_tick) begin
            sec_d = sec_inc;
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DISARMED;
      match_q <= 1'b0;
      sec_q   <= '0;
      snz_q   <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match;
      sec_q   <= sec_d;
      snz_q   <= snz_d;
    end
  end

  assign ringing    = (state_q == RINGING);
  assign snoozing   = (state_q == SNOOZE);
  assign snooze_cnt = snz_q;

`ifdef ALARM_BEEP_PATTERN_EN
  // Enable from the next state so the first beep lands on the same edge as ringing.
  beep_gen #(
    .ON_CYCLES  (BEEP_ON_CYCLES),
    .OFF_CYCLES (BEEP_OFF_CYCLES)
  ) u_beep (
    .clk     (clk),
    .reset   (reset),
    .enable  (state_d == RINGING),
    .speaker (speaker_out)
  );
`else
  assign speaker_out = ringing;
`endif

endmodule
